// File: rtl/statevector_pair_memory_if.sv
// Gate-engine, host and control signals of the statevector pair memory.
// The memory is the slave; the gate engine / host side is the master.
interface statevector_pair_memory_if #(
    parameter int unsigned NUM_QUBITS      = 3,
    parameter int unsigned AMPLITUDE_WIDTH = 32
);
    localparam int unsigned TW = $clog2(NUM_QUBITS);
    localparam int unsigned AW = NUM_QUBITS;
    localparam int unsigned BW = NUM_QUBITS - 1;
    localparam int unsigned DW = AMPLITUDE_WIDTH;

    logic          init_req;
    logic          busy;

    logic          rd_valid;
    logic          rd_ready;
    logic [TW-1:0] rd_target;
    logic [BW-1:0] rd_base;

    logic          rsp_valid;
    logic [DW-1:0] rsp_lo_re;
    logic [DW-1:0] rsp_lo_im;
    logic [DW-1:0] rsp_hi_re;
    logic [DW-1:0] rsp_hi_im;

    logic          wr_valid;
    logic          wr_ready;
    logic [TW-1:0] wr_target;
    logic [BW-1:0] wr_base;
    logic [DW-1:0] wr_lo_re;
    logic [DW-1:0] wr_lo_im;
    logic [DW-1:0] wr_hi_re;
    logic [DW-1:0] wr_hi_im;

    logic          host_en;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_din_re;
    logic [DW-1:0] host_din_im;
    logic          host_ready;
    logic [DW-1:0] host_dout_re;
    logic [DW-1:0] host_dout_im;

    logic          err;

    modport master (
        output init_req,
        output rd_valid, rd_target, rd_base,
        output wr_valid, wr_target, wr_base, wr_lo_re, wr_lo_im, wr_hi_re, wr_hi_im,
        output host_en, host_we, host_addr, host_din_re, host_din_im,
        input  busy, rd_ready, wr_ready, host_ready,
        input  rsp_valid, rsp_lo_re, rsp_lo_im, rsp_hi_re, rsp_hi_im,
        input  host_dout_re, host_dout_im, err
    );

    modport slave (
        input  init_req,
        input  rd_valid, rd_target, rd_base,
        input  wr_valid, wr_target, wr_base, wr_lo_re, wr_lo_im, wr_hi_re, wr_hi_im,
        input  host_en, host_we, host_addr, host_din_re, host_din_im,
        output busy, rd_ready, wr_ready, host_ready,
        output rsp_valid, rsp_lo_re, rsp_lo_im, rsp_hi_re, rsp_hi_im,
        output host_dout_re, host_dout_im, err
    );
endinterface

// File: rtl/statevector_pair_memory.sv
// Dual-port statevector store serving amplitude pairs (i, i|1<<t) per cycle,
// with a self-clearing |0..0> init sequence and an idle-only host port.
module statevector_pair_memory #(
    parameter int unsigned               NUM_QUBITS      = 3,
    parameter int unsigned               AMPLITUDE_WIDTH = 32,
    parameter logic [AMPLITUDE_WIDTH-1:0] INIT_RE        = AMPLITUDE_WIDTH'(32'h3f800000)
) (
    input  logic                       clk,
    input  logic                       rst,
    statevector_pair_memory_if.slave   bus
);
    localparam int unsigned TW         = $clog2(NUM_QUBITS);
    localparam int unsigned AW         = NUM_QUBITS;
    localparam int unsigned BW         = NUM_QUBITS - 1;
    localparam int unsigned DW         = AMPLITUDE_WIDTH;
    localparam int unsigned NUM_STATES = 1 << NUM_QUBITS;

    typedef enum logic {ST_INIT, ST_IDLE} state_e;

    // Insert a zero at bit t of the pair index to form the low address.
    function automatic logic [AW-1:0] pair_lo(input logic [TW-1:0] t, input logic [BW-1:0] base);
        logic [AW-1:0] b;
        logic [AW-1:0] m;
        b = AW'(base);
        m = (AW'(1) << t) - AW'(1);
        return ((b & ~m) << 1) | (b & m);
    endfunction

    function automatic logic target_legal(input logic [TW-1:0] t);
        return 32'(t) < NUM_QUBITS;
    endfunction

    state_e        state_q, state_d;
    logic [AW-1:0] k_q, k_d;

    logic [DW-1:0] mem_re_q [NUM_STATES];
    logic [DW-1:0] mem_im_q [NUM_STATES];

    logic          rd_legal, wr_legal;
    logic [AW-1:0] rd_lo, rd_hi, wr_lo, wr_hi;

    logic          busy_c, open_c, rd_ready_c, wr_ready_c, host_ready_c;
    logic          rd_fire, wr_fire, host_fire;
    logic          p0_we, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_re, p0_im, p1_re, p1_im;

    logic          rsp_valid_q, rsp_valid_d;
    logic          err_q, err_d;
    logic [DW-1:0] rsp_lo_re_q, rsp_lo_re_d, rsp_lo_im_q, rsp_lo_im_d;
    logic [DW-1:0] rsp_hi_re_q, rsp_hi_re_d, rsp_hi_im_q, rsp_hi_im_d;
    logic [DW-1:0] host_dout_re_q, host_dout_re_d, host_dout_im_q, host_dout_im_d;

    always_comb begin
        rd_legal = target_legal(bus.rd_target);
        wr_legal = target_legal(bus.wr_target);
        rd_lo    = pair_lo(bus.rd_target, bus.rd_base);
        rd_hi    = rd_lo | (AW'(1) << bus.rd_target);
        wr_lo    = pair_lo(bus.wr_target, bus.wr_base);
        wr_hi    = wr_lo | (AW'(1) << bus.wr_target);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    // Next state: init walks two entries per cycle, init_req restarts it
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            ST_INIT: begin
                k_d = k_q + AW'(2);
                if (k_q == AW'(NUM_STATES - 2)) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (bus.init_req) begin
                    state_d = ST_INIT;
                    k_d     = '0;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Outputs: readiness priority (write > read > host) and RAM port muxing
    always_comb begin
        busy_c       = 1'b0;
        open_c       = 1'b0;
        rd_ready_c   = 1'b0;
        wr_ready_c   = 1'b0;
        host_ready_c = 1'b0;
        p0_we        = 1'b0;
        p0_addr      = '0;
        p0_re        = '0;
        p0_im        = '0;
        p1_we        = 1'b0;
        p1_addr      = '0;
        p1_re        = '0;
        p1_im        = '0;
        if (state_q == ST_INIT) begin
            busy_c  = 1'b1;
            p0_we   = 1'b1;
            p0_addr = k_q;
            p0_re   = (k_q == '0) ? INIT_RE : '0;
            p1_we   = 1'b1;
            p1_addr = k_q | AW'(1);
        end else begin
            open_c       = !rst && !bus.init_req;
            wr_ready_c   = open_c;
            rd_ready_c   = open_c && !bus.wr_valid;
            host_ready_c = open_c && !bus.wr_valid && !bus.rd_valid;
        end
        wr_fire   = bus.wr_valid && wr_ready_c;
        rd_fire   = bus.rd_valid && rd_ready_c;
        host_fire = bus.host_en && host_ready_c;
        if (wr_fire && wr_legal) begin
            p0_we   = 1'b1;
            p0_addr = wr_lo;
            p0_re   = bus.wr_lo_re;
            p0_im   = bus.wr_lo_im;
            p1_we   = 1'b1;
            p1_addr = wr_hi;
            p1_re   = bus.wr_hi_re;
            p1_im   = bus.wr_hi_im;
        end else if (host_fire && bus.host_we) begin
            p0_we   = 1'b1;
            p0_addr = bus.host_addr;
            p0_re   = bus.host_din_re;
            p0_im   = bus.host_din_im;
        end
    end

    always_ff @(posedge clk) begin
        if (p0_we) begin
            mem_re_q[p0_addr] <= p0_re;
            mem_im_q[p0_addr] <= p0_im;
        end
        if (p1_we) begin
            mem_re_q[p1_addr] <= p1_re;
            mem_im_q[p1_addr] <= p1_im;
        end
    end

    // Read data holds until the next read of the same kind
    always_comb begin
        rsp_valid_d    = rd_fire && rd_legal;
        err_d          = (rd_fire && !rd_legal) || (wr_fire && !wr_legal);
        rsp_lo_re_d    = rsp_lo_re_q;
        rsp_lo_im_d    = rsp_lo_im_q;
        rsp_hi_re_d    = rsp_hi_re_q;
        rsp_hi_im_d    = rsp_hi_im_q;
        host_dout_re_d = host_dout_re_q;
        host_dout_im_d = host_dout_im_q;
        if (rsp_valid_d) begin
            rsp_lo_re_d = mem_re_q[rd_lo];
            rsp_lo_im_d = mem_im_q[rd_lo];
            rsp_hi_re_d = mem_re_q[rd_hi];
            rsp_hi_im_d = mem_im_q[rd_hi];
        end
        if (host_fire && !bus.host_we) begin
            host_dout_re_d = mem_re_q[bus.host_addr];
            host_dout_im_d = mem_im_q[bus.host_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q    <= 1'b0;
            err_q          <= 1'b0;
            rsp_lo_re_q    <= '0;
            rsp_lo_im_q    <= '0;
            rsp_hi_re_q    <= '0;
            rsp_hi_im_q    <= '0;
            host_dout_re_q <= '0;
            host_dout_im_q <= '0;
        end else begin
            rsp_valid_q    <= rsp_valid_d;
            err_q          <= err_d;
            rsp_lo_re_q    <= rsp_lo_re_d;
            rsp_lo_im_q    <= rsp_lo_im_d;
            rsp_hi_re_q    <= rsp_hi_re_d;
            rsp_hi_im_q    <= rsp_hi_im_d;
            host_dout_re_q <= host_dout_re_d;
            host_dout_im_q <= host_dout_im_d;
        end
    end

    assign bus.busy         = busy_c;
    assign bus.rd_ready     = rd_ready_c;
    assign bus.wr_ready     = wr_ready_c;
    assign bus.host_ready   = host_ready_c;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_lo_re    = rsp_lo_re_q;
    assign bus.rsp_lo_im    = rsp_lo_im_q;
    assign bus.rsp_hi_re    = rsp_hi_re_q;
    assign bus.rsp_hi_im    = rsp_hi_im_q;
    assign bus.host_dout_re = host_dout_re_q;
    assign bus.host_dout_im = host_dout_im_q;
    assign bus.err          = err_q;
endmodule

// File: tb/tb_statevector_pair_memory.sv
// Scoreboard bench for statevector_pair_memory: stimulus pushes expected
// responses from an array model, a negedge monitor pops and compares them.
module tb_statevector_pair_memory;
    localparam int unsigned NQ  = 3;
    localparam int unsigned DW  = 32;
    localparam int unsigned NS  = 8;
    localparam int unsigned TW  = 2;
    localparam int unsigned BW  = 2;
    localparam logic [31:0] ONE = 32'h3f800000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    statevector_pair_memory_if #(.NUM_QUBITS(NQ), .AMPLITUDE_WIDTH(DW)) bus ();

    statevector_pair_memory #(
        .NUM_QUBITS(NQ), .AMPLITUDE_WIDTH(DW), .INIT_RE(ONE)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct { int unsigned cyc; logic [31:0] lo_re, lo_im, hi_re, hi_im; } rsp_t;
    typedef struct { int unsigned cyc; logic [31:0] re, im; } host_t;

    rsp_t        rsp_q [$];
    host_t       host_q[$];
    int unsigned err_q [$];
    logic [31:0] m_re [NS];
    logic [31:0] m_im [NS];
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < int'(NS); i++) begin
            m_re[i] = (i == 0) ? ONE : 32'h0;
            m_im[i] = 32'h0;
        end
    endfunction

    // Pair low address: base bits at and above t move up one place.
    function automatic int unsigned m_lo(input int unsigned t, input int unsigned base);
        return ((base >> t) << (t + 1)) | (base & ((1 << t) - 1));
    endfunction

    function automatic logic ready_of(input int kind);
        case (kind)
            0:       return bus.rd_ready;
            1:       return bus.wr_ready;
            default: return bus.host_ready;
        endcase
    endfunction

    task automatic wait_ready(input int kind, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ready_of(kind)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) flag($sformatf("handshake_timeout kind=%0d", kind));
    endtask

    task automatic gate_read(input int unsigned t, input int unsigned base);
        bit ok;
        int unsigned lo, hi;
        bus.rd_valid  = 1'b1;
        bus.rd_target = TW'(t);
        bus.rd_base   = BW'(base);
        wait_ready(0, ok);
        if (ok) begin
            if (t >= NQ) err_q.push_back(cyc);
            else begin
                lo = m_lo(t, base);
                hi = lo | (1 << t);
                rsp_q.push_back('{cyc, m_re[lo], m_im[lo], m_re[hi], m_im[hi]});
            end
        end
        @(posedge clk); #1;
        bus.rd_valid = 1'b0;
    endtask

    task automatic gate_write(input int unsigned t, input int unsigned base,
                              input logic [31:0] lr, input logic [31:0] li,
                              input logic [31:0] hr, input logic [31:0] hi_i);
        bit ok;
        int unsigned lo, hi;
        bus.wr_valid  = 1'b1;
        bus.wr_target = TW'(t);
        bus.wr_base   = BW'(base);
        bus.wr_lo_re  = lr;
        bus.wr_lo_im  = li;
        bus.wr_hi_re  = hr;
        bus.wr_hi_im  = hi_i;
        wait_ready(1, ok);
        if (ok) begin
            if (t >= NQ) err_q.push_back(cyc);
            else begin
                lo = m_lo(t, base);
                hi = lo | (1 << t);
                m_re[lo] = lr;  m_im[lo] = li;
                m_re[hi] = hr;  m_im[hi] = hi_i;
            end
        end
        @(posedge clk); #1;
        bus.wr_valid = 1'b0;
    endtask

    task automatic host_write(input int unsigned a, input logic [31:0] re, input logic [31:0] im);
        bit ok;
        bus.host_en     = 1'b1;
        bus.host_we     = 1'b1;
        bus.host_addr   = 3'(a);
        bus.host_din_re = re;
        bus.host_din_im = im;
        wait_ready(2, ok);
        if (ok) begin
            m_re[a] = re;
            m_im[a] = im;
        end
        @(posedge clk); #1;
        bus.host_en = 1'b0;
        bus.host_we = 1'b0;
    endtask

    task automatic host_read(input int unsigned a);
        bit ok;
        bus.host_en   = 1'b1;
        bus.host_we   = 1'b0;
        bus.host_addr = 3'(a);
        wait_ready(2, ok);
        if (ok) host_q.push_back('{cyc, m_re[a], m_im[a]});
        @(posedge clk); #1;
        bus.host_en = 1'b0;
    endtask

    // Counts busy cycles at negedges, checking the host port stays closed.
    task automatic measure_busy(input string name, input int already, input int exp);
        int n;
        n = already;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            n++;
            check({name, "_host_ready"}, 32'(bus.host_ready), 32'd0);
        end
        check(name, 32'(n), 32'(exp));
    endtask

    // Monitor: compares every presented response against the scoreboard.
    always @(negedge clk) begin
        rsp_t  r;
        host_t h;
        if (mon_en) begin
            if (bus.rsp_valid) begin
                if (rsp_q.size() == 0) flag("rsp_valid_unexpected");
                else begin
                    r = rsp_q.pop_front();
                    check("rsp_latency", cyc, r.cyc + 1);
                    check("rsp_lo_re", bus.rsp_lo_re, r.lo_re);
                    check("rsp_lo_im", bus.rsp_lo_im, r.lo_im);
                    check("rsp_hi_re", bus.rsp_hi_re, r.hi_re);
                    check("rsp_hi_im", bus.rsp_hi_im, r.hi_im);
                end
            end else if (rsp_q.size() != 0 && rsp_q[0].cyc + 1 <= cyc) begin
                flag("rsp_valid_missing");
                void'(rsp_q.pop_front());
            end
            if (bus.err) begin
                if (err_q.size() == 0) flag("err_unexpected");
                else check("err_latency", cyc, err_q.pop_front() + 1);
            end else if (err_q.size() != 0 && err_q[0] + 1 <= cyc) begin
                flag("err_missing");
                void'(err_q.pop_front());
            end
            if (host_q.size() != 0 && host_q[0].cyc + 1 == cyc) begin
                h = host_q.pop_front();
                check("host_dout_re", bus.host_dout_re, h.re);
                check("host_dout_im", bus.host_dout_im, h.im);
            end
        end
    end

    initial begin
        logic [31:0] a, b, c, d;
        bus.init_req = 1'b0;
        bus.rd_valid = 1'b0;  bus.rd_target = '0;  bus.rd_base = '0;
        bus.wr_valid = 1'b0;  bus.wr_target = '0;  bus.wr_base = '0;
        bus.wr_lo_re = '0;    bus.wr_lo_im = '0;   bus.wr_hi_re = '0;  bus.wr_hi_im = '0;
        bus.host_en = 1'b0;   bus.host_we = 1'b0;  bus.host_addr = '0;
        bus.host_din_re = '0; bus.host_din_im = '0;
        model_reset();

        // Reset state and init duration
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_rd_ready", 32'(bus.rd_ready), 32'd0);
        check("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
        check("rst_host_ready", 32'(bus.host_ready), 32'd0);
        check("rst_rsp_lo_re", bus.rsp_lo_re, 32'd0);
        check("rst_rsp_hi_im", bus.rsp_hi_im, 32'd0);
        check("rst_host_dout_re", bus.host_dout_re, 32'd0);
        check("rst_host_dout_im", bus.host_dout_im, 32'd0);
        mon_en = 1'b1;
        measure_busy("init_busy_cycles", 1, 4);
        @(posedge clk); #1;
        for (int i = 0; i < int'(NS); i++) host_read(i);

        // Pair read t=1 base=2 -> addresses 4 and 6
        a = $urandom; b = $urandom; c = $urandom; d = $urandom;
        host_write(4, a, b);
        host_write(6, c, d);
        gate_read(1, 2);

        // Pair write t=2 base=1 -> addresses 1 and 5
        gate_write(2, 1, 32'h3f000000, 32'h3f000000, 32'h3f000000, 32'h3f000000);
        host_read(1);
        host_read(5);

        // Simultaneous write and read: write first, read sees new data
        bus.wr_valid = 1'b1;  bus.wr_target = 2'd0;  bus.wr_base = 2'd3;
        bus.wr_lo_re = $urandom;  bus.wr_lo_im = $urandom;
        bus.wr_hi_re = $urandom;  bus.wr_hi_im = $urandom;
        bus.rd_valid = 1'b1;  bus.rd_target = 2'd0;  bus.rd_base = 2'd3;
        bus.host_en  = 1'b1;  bus.host_we = 1'b0;    bus.host_addr = 3'd0;
        @(negedge clk);
        check("prio_rd_ready", 32'(bus.rd_ready), 32'd0);
        check("prio_host_ready", 32'(bus.host_ready), 32'd0);
        check("prio_wr_ready", 32'(bus.wr_ready), 32'd1);
        m_re[6] = bus.wr_lo_re;  m_im[6] = bus.wr_lo_im;
        m_re[7] = bus.wr_hi_re;  m_im[7] = bus.wr_hi_im;
        @(posedge clk); #1;
        bus.wr_valid = 1'b0;
        @(negedge clk);
        check("prio_rd_ready_after", 32'(bus.rd_ready), 32'd1);
        check("prio_host_ready_rd", 32'(bus.host_ready), 32'd0);
        rsp_q.push_back('{cyc, m_re[6], m_im[6], m_re[7], m_im[7]});
        @(posedge clk); #1;
        bus.rd_valid = 1'b0;
        bus.host_en  = 1'b0;

        // Illegal targets: err pulse, no response, memory untouched
        gate_read(3, 1);
        gate_write(3, 2, $urandom, $urandom, $urandom, $urandom);
        for (int i = 0; i < int'(NS); i++) host_read(i);

        // Back-to-back reads, then randomized mix
        for (int i = 0; i < 4; i++) gate_read($urandom_range(0, 2), $urandom_range(0, 3));
        for (int i = 0; i < 120; i++) begin
            case ($urandom_range(0, 3))
                0: gate_read($urandom_range(0, 3), $urandom_range(0, 3));
                1: gate_write($urandom_range(0, 3), $urandom_range(0, 3),
                              $urandom, $urandom, $urandom, $urandom);
                2: host_write($urandom_range(0, 7), $urandom, $urandom);
                default: host_read($urandom_range(0, 7));
            endcase
        end

        // init_req after filling memory: host locked out, state back to |000>
        for (int i = 0; i < int'(NS); i++) host_write(i, 32'(i * 100), 32'(i * 100 + 7));
        bus.init_req = 1'b1;
        bus.host_en  = 1'b1;
        bus.host_we  = 1'b0;
        bus.host_addr = 3'd3;
        @(negedge clk);
        check("init_req_host_ready", 32'(bus.host_ready), 32'd0);
        @(posedge clk); #1;
        bus.init_req = 1'b0;
        measure_busy("reinit_busy_cycles", 0, 4);
        bus.host_en = 1'b0;
        model_reset();
        @(posedge clk); #1;
        for (int i = 0; i < int'(NS); i++) host_read(i);

        // Reset alongside a read request: no response, init restarts
        host_write(2, $urandom, $urandom);
        rst = 1'b1;
        bus.rd_valid = 1'b1;  bus.rd_target = 2'd0;  bus.rd_base = 2'd1;
        @(negedge clk);
        check("rst_rd_ready_block", 32'(bus.rd_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.rd_valid = 1'b0;
        measure_busy("rst_busy_cycles", 0, 4);
        model_reset();
        @(posedge clk); #1;
        host_read(2);
        gate_read(0, 0);
        gate_read(1, 0);

        repeat (3) @(negedge clk);
        check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
        check("err_queue_drained", 32'(err_q.size()), 32'd0);
        check("host_queue_drained", 32'(host_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/statevector_pair_memory.md
# statevector_pair_memory

Parametrised statevector store for the FPGA quantum simulator, the successor to the single-amplitude dual-port statevector RAM. It holds 2^NUM_QUBITS complex amplitudes and serves gate-engine pair accesses: for a target qubit t it reads or writes amplitudes i and i|(1<<t) in one cycle. It adds a self-clearing initialisation FSM that loads |0…0⟩, a valid/ready request handshake, and a host debug port that runs only when the gate path is idle. It sits between the gate-apply pipeline and the host/measurement logic.

## Interface
- NUM_QUBITS, 3, qubit count; must be ≥2; NUM_STATES = 2**NUM_QUBITS
- AMPLITUDE_WIDTH, 32, bits per real/imag component
- INIT_RE, 32'h3f800000, real part written to address 0 during init (1.0 in IEEE-754)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- init_req  in  1  pulse in IDLE to restart initialisation
- busy  out  1  high while the INIT state is active
- rd_valid / rd_ready  in / out  1 / 1  pair-read request handshake
- rd_target  in  $clog2(NUM_QUBITS)  target qubit t
- rd_base  in  NUM_QUBITS-1  pair index, with bit t removed
- rsp_valid  out  1  pair-read data valid
- rsp_lo_re, rsp_lo_im, rsp_hi_re, rsp_hi_im  out  AMPLITUDE_WIDTH each  amplitudes at addr_lo and addr_hi
- wr_valid / wr_ready  in / out  1 / 1  pair write-back handshake
- wr_target, wr_base  in  as for rd_*  write-back addressing
- wr_lo_re, wr_lo_im, wr_hi_re, wr_hi_im  in  AMPLITUDE_WIDTH each  data to write
- host_en, host_we  in  1, 1  host access strobe and write enable
- host_addr  in  NUM_QUBITS  host address
- host_din_re, host_din_im  in  AMPLITUDE_WIDTH each  host write data
- host_ready  out  1  host access is accepted this cycle
- host_dout_re, host_dout_im  out  AMPLITUDE_WIDTH each  host read data
- err  out  1  one-cycle pulse on an illegal target

## Operation
- Address formation: addr_lo = {base[NQ-2:t], 1'b0, base[t-1:0]}; addr_hi = addr_lo | (1<<t).
- Storage is true dual-port RAM. Port 0 serves addr_lo, port 1 serves addr_hi, and host accesses use port 0.
- States:
  - INIT: counter k runs from 0 to NUM_STATES-1. Each cycle writes addr k with re = (k==0 ? INIT_RE : 0) and im = 0, using both ports (k and k+1) so that INIT completes in NUM_STATES/2 cycles. INIT then moves to IDLE.
  - IDLE: serves gate requests and host accesses. init_req moves to INIT, and init_req takes priority over all requests in that cycle.
- Readiness:
  - rd_ready, wr_ready and host_ready are all 0 in INIT.
  - Write-back has priority: when wr_valid=1, rd_ready=0 and host_ready=0.
  - Read beats host: when rd_valid=1, host_ready=0.
- A handshake completes when valid && ready.
- A gate request with target ≥ NUM_QUBITS is accepted (ready=1) but performs no access and no rsp_valid. It asserts err on the next cycle.
- A host access is taken only when host_en && host_ready. A host write updates the addressed entry. A host read returns data on host_dout.
- rsp_* and host_dout hold their last value until the next read of the same kind.

## Timing
- Reset (rst=1 at an edge), from the next cycle:
  - busy=1, rsp_valid=0, err=0, all ready outputs 0.
  - rsp_* = 0 and host_dout = 0.
  - The FSM enters INIT with k=0.
- rst asserted mid-INIT or mid-request restarts INIT from k=0. Any accepted read in flight produces no rsp_valid.
- INIT lasts exactly NUM_STATES/2 cycles. busy falls in the cycle after the last init write.
- Read latency is 1 cycle. rsp_valid pulses high the cycle after the rd handshake, and back-to-back accepted reads give back-to-back rsp_valid.
- A write is visible to a read accepted in the next cycle.
- There is no same-cycle read/write overlap, because priority excludes it.
- Host read latency is 1 cycle. A host read and a gate read never occur in the same cycle.
- addr_lo and addr_hi always differ, so the dual-port writes never collide.

## Test plan
- Reset, then wait for busy to fall; expected fall after 4 cycles for NQ=3. Host-read addresses 0–7 -> addr0 = 3f800000/0, all others 0/0.
- Pair read with t=1, base=2'b10 -> addr_lo=4 and addr_hi=6. After host-writing 4 = (a,b) and 6 = (c,d), rsp_lo=(a,b), rsp_hi=(c,d), with rsp_valid exactly 1 cycle after the handshake.
- Pair write with t=2, base=2'b01 and values (0x3f000000, 0x3f000000) lo/hi -> host reads of addresses 1 and 5 both return 3f000000/3f000000.
- Assert wr_valid and rd_valid together -> rd_ready=0 until the write completes. The read is then accepted and returns the newly written data.
- rd_target=3 with NQ=3 -> accepted, err pulses 1 cycle later, no rsp_valid, memory unchanged.
- Raise init_req (or rst) after writing all 8 addresses to i*100 -> busy reasserts, host_ready=0 throughout. Afterwards, the state reads back as |000⟩ again.
